// File: rtl/parking_billing_unit_pkg.sv
// Shared sizes and types for the parking-lot billing unit.
package parking_billing_unit_pkg;
  localparam int SLOTS  = 4;
  localparam int TIME_W = 4;
  localparam int COST_W = 8;

  typedef logic [1:0]        slot_t;
  typedef logic [TIME_W-1:0] time_t;
endpackage

// File: rtl/parking_billing_unit_add_sub4.sv
// 4-bit ripple adder/subtractor; mode=1 computes a - b as a + ~b + 1.
module add_sub4 (
  input  logic       mode,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       carry_borrow
);
  logic [3:0] b_eff;
  logic [4:0] carry;

  assign b_eff = b ^ {4{mode}};

  always_comb begin
    carry[0] = mode;
    sum      = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  // In subtract mode a missing carry-out means the result borrowed.
  assign carry_borrow = mode ? ~carry[4] : carry[4];
endmodule

// File: rtl/parking_billing_unit.sv
// Four-slot parking controller: hour counter, lowest-free allocation, exit billing.
module parking_billing_unit
  import parking_billing_unit_pkg::*;
#(
  parameter logic [3:0] RATE = 4'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        arrive,
  input  logic        depart,
  input  logic [1:0]  depart_slot,
  output logic [3:0]  lot_free,
  output logic        full,
  output logic [3:0]  time_now,
  output logic        assign_valid,
  output logic [1:0]  assign_slot,
  output logic        arrive_reject,
  output logic        bill_valid,
  output logic [3:0]  duration,
  output logic [7:0]  cost,
  output logic        wrapped,
  output logic        depart_err
);
  logic [SLOTS-1:0]  free_q, free_next;
  time_t             time_q;
  time_t             entry_q [SLOTS];
  slot_t             free_idx;
  logic              arr_ok, dep_ok;
  time_t             diff;
  logic              borrow;
  logic [COST_W-1:0] product;

  assign full   = (free_q == '0);
  assign arr_ok = arrive && !full;
  assign dep_ok = depart && !free_q[depart_slot];

  // Scan downwards so the lowest free index wins.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_q[i]) free_idx = slot_t'(i);
    end
  end

  add_sub4 u_sub (
    .mode        (1'b1),
    .a           (time_q),
    .b           (entry_q[depart_slot]),
    .sum         (diff),
    .carry_borrow(borrow)
  );

  assign product = COST_W'(diff) * COST_W'(RATE);

  // The arrival slot is chosen from the pre-departure map; the departing slot is occupied, so they never collide.
  always_comb begin
    free_next = free_q;
    if (dep_ok) free_next[depart_slot] = 1'b1;
    if (arr_ok) free_next[free_idx]    = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q        <= '0;
      free_q        <= '1;
      // NOTE: the entry file is small and must read as zero after reset, so it is reset like any other register.
      for (int i = 0; i < SLOTS; i++) entry_q[i] <= '0;
      assign_valid  <= 1'b0;
      assign_slot   <= '0;
      arrive_reject <= 1'b0;
      bill_valid    <= 1'b0;
      depart_err    <= 1'b0;
      duration      <= '0;
      cost          <= '0;
      wrapped       <= 1'b0;
    end else begin
      if (tick) time_q <= time_q + TIME_W'(1);
      free_q        <= free_next;
      assign_valid  <= arr_ok;
      arrive_reject <= arrive && full;
      bill_valid    <= dep_ok;
      depart_err    <= depart && free_q[depart_slot];
      if (arr_ok) begin
        entry_q[free_idx] <= time_q;
        assign_slot       <= free_idx;
      end
      if (dep_ok) begin
        duration <= diff;
        cost     <= product;
        wrapped  <= borrow;
      end
    end
  end

  assign lot_free = free_q;
  assign time_now = time_q;
endmodule

// File: tb/tb_parking_billing_unit.sv
// Self-checking bench: directed vector table, hand-written corner cases, random run vs a reference model.
module tb_parking_billing_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, arrive, depart;
  logic [1:0] depart_slot;
  logic [3:0] lot_free, time_now, duration;
  logic       full, assign_valid, arrive_reject, bill_valid, wrapped, depart_err;
  logic [1:0] assign_slot;
  logic [7:0] cost;

  parking_billing_unit #(.RATE(4'd5)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .arrive(arrive), .depart(depart),
    .depart_slot(depart_slot), .lot_free(lot_free), .full(full), .time_now(time_now),
    .assign_valid(assign_valid), .assign_slot(assign_slot), .arrive_reject(arrive_reject),
    .bill_valid(bill_valid), .duration(duration), .cost(cost), .wrapped(wrapped),
    .depart_err(depart_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       t, a, d;
    bit [1:0] ds;
    bit [3:0] free, tm;
    bit       av;
    bit [1:0] slot;
    bit       rej, bv;
    bit [3:0] dur;
    bit [7:0] cost;
    bit       wrap, err;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model state.
  bit       occ [4];
  int       ent [4];
  int       now_m;
  int       dur_m, cost_m;
  bit       wrap_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic row(input bit t, a, d, input bit [1:0] ds, input bit [3:0] free, tm,
                     input bit av, input bit [1:0] slot, input bit rej, bv,
                     input bit [3:0] dur, input bit [7:0] c, input bit wrap, err);
    vec_t v;
    v.t = t; v.a = a; v.d = d; v.ds = ds; v.free = free; v.tm = tm;
    v.av = av; v.slot = slot; v.rej = rej; v.bv = bv;
    v.dur = dur; v.cost = c; v.wrap = wrap; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic compare(input string tag, input vec_t v);
    check({tag, " lot_free"}, 32'(lot_free), 32'(v.free));
    check({tag, " full"}, 32'(full), 32'(v.free == 4'b0000));
    check({tag, " time_now"}, 32'(time_now), 32'(v.tm));
    check({tag, " assign_valid"}, 32'(assign_valid), 32'(v.av));
    if (v.av) check({tag, " assign_slot"}, 32'(assign_slot), 32'(v.slot));
    check({tag, " arrive_reject"}, 32'(arrive_reject), 32'(v.rej));
    check({tag, " bill_valid"}, 32'(bill_valid), 32'(v.bv));
    check({tag, " duration"}, 32'(duration), 32'(v.dur));
    check({tag, " cost"}, 32'(cost), 32'(v.cost));
    check({tag, " wrapped"}, 32'(wrapped), 32'(v.wrap));
    check({tag, " depart_err"}, 32'(depart_err), 32'(v.err));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply(input bit t, a, d, input bit [1:0] ds);
    tick = t; arrive = a; depart = d; depart_slot = ds;
    @(posedge clk); #1;
    tick = 0; arrive = 0; depart = 0; depart_slot = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin occ[i] = 0; ent[i] = 0; end
    now_m = 0; dur_m = 0; cost_m = 0; wrap_m = 0;
  endtask

  task automatic model_step(input bit t, a, d, input bit [1:0] ds, output vec_t e);
    int s;
    e.t = t; e.a = a; e.d = d; e.ds = ds;
    e.av = 0; e.slot = 0; e.rej = 0; e.bv = 0; e.err = 0;
    s = -1;
    if (a) begin
      for (int i = 3; i >= 0; i--) if (!occ[i]) s = i;
      if (s < 0) e.rej = 1;
    end
    if (d) begin
      if (occ[ds]) begin
        dur_m  = (now_m + 16 - ent[ds]) % 16;
        wrap_m = ent[ds] > now_m;
        cost_m = dur_m * 5;
        occ[ds] = 0;
        e.bv = 1;
      end else e.err = 1;
    end
    if (s >= 0) begin
      occ[s] = 1; ent[s] = now_m; e.av = 1; e.slot = 2'(s);
    end
    if (t) now_m = (now_m + 1) % 16;
    for (int i = 0; i < 4; i++) e.free[i] = !occ[i];
    e.tm = 4'(now_m); e.dur = 4'(dur_m); e.cost = 8'(cost_m); e.wrap = wrap_m;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t e;
    tick = 0; arrive = 0; depart = 0; depart_slot = 0;
    do_reset();
    e = '{free: 4'b1111, default: 0};
    compare("reset", e);

    // Park at 2, leave at 5.
    row(1,0,0,0, 4'b1111, 1, 0,0,0,0, 0,0,0,0);
    row(1,0,0,0, 4'b1111, 2, 0,0,0,0, 0,0,0,0);
    row(0,1,0,0, 4'b1110, 2, 1,0,0,0, 0,0,0,0);
    row(1,0,0,0, 4'b1110, 3, 0,0,0,0, 0,0,0,0);
    row(1,0,0,0, 4'b1110, 4, 0,0,0,0, 0,0,0,0);
    row(1,0,0,0, 4'b1110, 5, 0,0,0,0, 0,0,0,0);
    row(0,0,1,0, 4'b1111, 5, 0,0,0,1, 3,15,0,0);
    // Advance to hour 1, fill the lot, overflow.
    for (int i = 6; i <= 17; i++) row(1,0,0,0, 4'b1111, 4'(i % 16), 0,0,0,0, 3,15,0,0);
    row(0,1,0,0, 4'b1110, 1, 1,0,0,0, 3,15,0,0);
    row(0,1,0,0, 4'b1100, 1, 1,1,0,0, 3,15,0,0);
    row(0,1,0,0, 4'b1000, 1, 1,2,0,0, 3,15,0,0);
    row(0,1,0,0, 4'b0000, 1, 1,3,0,0, 3,15,0,0);
    row(0,1,0,0, 4'b0000, 1, 0,0,1,0, 3,15,0,0);
    // Full lot: simultaneous arrive and depart slot 2.
    row(0,1,1,2, 4'b0100, 1, 0,0,1,1, 0,0,0,0);
    row(0,1,0,0, 4'b0000, 1, 1,2,0,0, 0,0,0,0);
    // Free slot 3, re-park at 14 with a same-cycle tick on the last step, leave at 2.
    row(0,0,1,3, 4'b1000, 1, 0,0,0,1, 0,0,0,0);
    for (int i = 2; i <= 13; i++) row(1,0,0,0, 4'b1000, 4'(i), 0,0,0,0, 0,0,0,0);
    row(1,0,0,0, 4'b1000, 14, 0,0,0,0, 0,0,0,0);
    row(1,1,0,0, 4'b0000, 15, 1,3,0,0, 0,0,0,0);
    for (int i = 16; i <= 18; i++) row(1,0,0,0, 4'b0000, 4'(i % 16), 0,0,0,0, 0,0,0,0);
    row(0,0,1,3, 4'b1000, 2, 0,0,0,1, 4,20,1,0);
    // Depart on an already-free slot.
    row(0,0,1,3, 4'b1000, 2, 0,0,0,0, 4,20,1,1);
    row(0,0,0,0, 4'b1000, 2, 0,0,0,0, 4,20,1,0);

    foreach (vecs[i]) begin
      apply(vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].ds);
      compare($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-stay takes effect without a clock edge.
    #2 rst_n = 0;
    #1;
    e = '{free: 4'b1111, default: 0};
    compare("async_reset", e);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    compare("after_reset", e);

    // Random traffic against the reference model.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit t, a, d;
      bit [1:0] ds;
      t  = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 3) == 0);
      ds = 2'($urandom_range(0, 3));
      model_step(t, a, d, ds, e);
      apply(t, a, d, ds);
      compare($sformatf("rnd%0d", n), e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
